// File: rtl/jtoutrun_pkg.sv
// Shared definitions for the OutRun main-to-sub bus requester.
// State encoding and the open-bus read value.
package jtoutrun_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DONE    = 3'd3,
    ST_LINGER  = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam logic [15:0] OPEN_BUS = 16'hffff;

endpackage

// File: rtl/jtoutrun_subreq.sv
// Main-CPU-side requester for the sub CPU bus: asks for the bus, waits for it to
// settle, performs one access, then keeps the bus briefly before handing it back.
module jtoutrun_subreq
  import jtoutrun_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int TOUT   = 1023,
  parameter int HOLD   = 8,
  parameter int CW     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        main_cs,
  input  logic        main_rnw,
  input  logic        sub_ok,
  input  logic [15:0] sub_din,
  output logic        sub_br,
  output logic        main_ok,
  output logic [15:0] main_dout,
  output logic        tout_err,
  output logic        busy
);

  localparam int HOLD_M1 = (HOLD > 0) ? HOLD - 1 : 0;
  localparam logic [CW-1:0] TOUT_C   = CW'(TOUT);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_M1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          sub_br_nx, main_ok_nx, tout_err_nx, busy_nx;
  logic [15:0]   main_dout_nx;
  logic          rnw, rnw_nx;
  logic          tflag, tflag_nx;   // current access ended by timeout

  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt_inc;
    sub_br_nx    = sub_br;
    main_ok_nx   = main_ok;
    main_dout_nx = main_dout;
    tout_err_nx  = tout_err;
    rnw_nx       = rnw;
    tflag_nx     = tflag;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (main_cs && !main_ok) begin
          state_nx  = ST_REQ;
          sub_br_nx = 1'b1;
          rnw_nx    = main_rnw;
          tflag_nx  = 1'b0;
        end
      end
      ST_REQ: begin
        if (!main_cs) begin
          state_nx  = ST_RELEASE;
          sub_br_nx = 1'b0;
          cnt_nx    = '0;
        end else if (sub_ok) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end else if (cnt == TOUT_C) begin
          state_nx     = ST_DONE;
          cnt_nx       = '0;
          tout_err_nx  = 1'b1;
          tflag_nx     = 1'b1;
          main_dout_nx = OPEN_BUS;
          main_ok_nx   = 1'b1;
        end
      end
      ST_SETTLE: begin
        // abort takes priority over a completing count
        if (!main_cs) begin
          state_nx  = ST_RELEASE;
          sub_br_nx = 1'b0;
          cnt_nx    = '0;
        end else if (!sub_ok) begin
          cnt_nx = '0;
        end else if (cnt == SETTLE_C) begin
          state_nx   = ST_DONE;
          cnt_nx     = '0;
          main_ok_nx = 1'b1;
          if (rnw) main_dout_nx = sub_din;
        end
      end
      ST_DONE: begin
        cnt_nx = '0;
        if (!main_cs) begin
          main_ok_nx = 1'b0;
          if (HOLD == 0 || tflag) begin
            state_nx  = ST_RELEASE;
            sub_br_nx = 1'b0;
          end else begin
            state_nx = ST_LINGER;
          end
        end
      end
      ST_LINGER: begin
        // a new access reuses the granted bus but still re-checks settling
        if (main_cs && !main_ok) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
          rnw_nx   = main_rnw;
        end else if (cnt == HOLD_C) begin
          state_nx  = ST_RELEASE;
          sub_br_nx = 1'b0;
          cnt_nx    = '0;
        end
      end
      ST_RELEASE: begin
        cnt_nx    = '0;
        sub_br_nx = 1'b0;
        if (!sub_ok) state_nx = ST_IDLE;
      end
      default: begin
        state_nx   = ST_IDLE;
        cnt_nx     = '0;
        sub_br_nx  = 1'b0;
        main_ok_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sub_br    <= 1'b0;
      main_ok   <= 1'b0;
      main_dout <= OPEN_BUS;
      tout_err  <= 1'b0;
      busy      <= 1'b0;
      rnw       <= 1'b1;
      tflag     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sub_br    <= sub_br_nx;
      main_ok   <= main_ok_nx;
      main_dout <= main_dout_nx;
      tout_err  <= tout_err_nx;
      busy      <= busy_nx;
      rnw       <= rnw_nx;
      tflag     <= tflag_nx;
    end
  end

endmodule

// File: tb/tb_jtoutrun_subreq.sv
// Randomized bench for jtoutrun_subreq: each access is predicted from the
// grant/settle/timeout rules over a planned sub_ok sample sequence.
module tb_jtoutrun_subreq;

  localparam int SETTLE = 2;
  localparam int TOUT   = 15;
  localparam int HOLD   = 8;
  localparam int CW     = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        main_cs, main_rnw, sub_ok;
  logic [15:0] sub_din;
  logic        sub_br, main_ok, tout_err, busy;
  logic [15:0] main_dout;

  int          vec = 0;
  int          errs = 0;
  logic [15:0] exp_dout;
  logic        exp_terr;
  bit          lingering;

  jtoutrun_subreq #(.SETTLE(SETTLE), .TOUT(TOUT), .HOLD(HOLD), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .main_cs  (main_cs),
    .main_rnw (main_rnw),
    .sub_ok   (sub_ok),
    .sub_din  (sub_din),
    .sub_br   (sub_br),
    .main_ok  (main_ok),
    .main_dout(main_dout),
    .tout_err (tout_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One main-bus access. lin: bus is still held from a previous access.
  // g: first edge where the sub side reports grant; glitch drops it for gl edges.
  task automatic access(input bit lin, input int g, input bit glitch, input int gl,
                        input bit rnw, input bit fix, input logic [15:0] fval,
                        output bit to);
    logic        s [0:63];
    logic [15:0] d [0:63];
    int          st, dn, run, hold;
    logic [15:0] want;
    for (int k = 0; k < 64; k++) begin
      s[k] = lin ? 1'b1 : (k >= g);
      if (glitch && k > g && k <= g + gl) s[k] = 1'b0;
      d[k] = fix ? fval : 16'($urandom);
    end
    // grant must arrive by edge TOUT+2 or the access times out there
    to = 1'b1; st = 0; dn = TOUT + 2;
    if (lin) begin
      to = 1'b0; st = 1;
    end else begin
      for (int k = 2; k <= TOUT + 2; k++)
        if (to && s[k]) begin st = k; to = 1'b0; end
    end
    // data is taken once SETTLE+1 consecutive high samples follow the grant
    if (!to) begin
      run = 0; dn = 0;
      for (int k = st + 1; k < 64; k++)
        if (dn == 0) begin
          run = s[k] ? run + 1 : 0;
          if (run == SETTLE + 1) dn = k;
        end
    end
    want = to ? 16'hffff : (rnw ? d[dn] : exp_dout);

    main_rnw = rnw;
    main_cs  = 1'b1;
    for (int k = 1; k <= dn; k++) begin
      sub_ok  = s[k];
      sub_din = d[k];
      cyc();
      if (k == 1) chk("br_on_req", sub_br, 1);
      if (k < dn) chk("ok_early", main_ok, 0);
    end
    exp_dout = want;
    if (to) exp_terr = 1'b1;
    chk("ok_done", main_ok, 1);
    chk("dout_done", main_dout, want);
    chk("terr_done", tout_err, exp_terr);
    chk("busy_done", busy, 1);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      sub_din = 16'($urandom);
      cyc();
      chk("ok_hold", main_ok, 1);
      chk("dout_hold", main_dout, want);
    end
    main_cs  = 1'b0;
    main_rnw = 1'($urandom);
    cyc();
    chk("ok_drop", main_ok, 0);
    chk("br_after", sub_br, !to);
    if (to) begin
      cyc();
      chk("idle_after_to", busy, 0);
    end
  endtask

  task automatic linger_release();
    int r;
    for (int j = 1; j <= HOLD; j++) begin
      cyc();
      chk("linger_br", sub_br, (j < HOLD));
    end
    r = $urandom_range(0, 2);
    repeat (r) begin
      cyc();
      chk("release_busy", busy, 1);
    end
    sub_ok = 1'b0;
    cyc();
    chk("release_idle", busy, 0);
    lingering = 1'b0;
  endtask

  task automatic go(input bit lin, input int g, input bit glitch, input int gl,
                    input bit rnw, input bit fix, input logic [15:0] fval);
    bit to;
    if (!lin && lingering) linger_release();
    access(lin, g, glitch, gl, rnw, fix, fval, to);
    lingering = !to;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; main_cs = 1'b0; main_rnw = 1'b1; sub_ok = 1'b0; sub_din = 16'h0;
    exp_dout = 16'hffff; exp_terr = 1'b0; lingering = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br", sub_br, 0);
    chk("rst_ok", main_ok, 0);
    chk("rst_dout", main_dout, 16'hffff);
    chk("rst_terr", tout_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();

    go(0, 5, 0, 0, 1, 1, 16'h1234);     // read, grant at edge 5
    go(0, 2, 0, 0, 0, 0, 16'h0);        // write, immediate grant
    repeat (2) begin cyc(); chk("linger_hold", sub_br, 1); end
    go(1, 0, 0, 0, 1, 0, 16'h0);        // back-to-back read from held bus
    go(0, 4, 1, 3, 1, 0, 16'h0);        // grant glitch
    go(0, 99, 0, 0, 1, 0, 16'h0);       // never granted
    if (lingering) linger_release();

    // abort while requesting
    main_rnw = 1'b1; main_cs = 1'b1; sub_ok = 1'b0;
    cyc(); chk("abreq_br", sub_br, 1);
    cyc(); cyc();
    main_cs = 1'b0;
    cyc();
    chk("abreq_br_drop", sub_br, 0);
    chk("abreq_ok", main_ok, 0);
    cyc();
    chk("abreq_idle", busy, 0);

    // abort on the same edge the settle count completes
    main_cs = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sub_ok = (k >= 2); sub_din = 16'($urandom);
      cyc();
      chk("abset_ok_early", main_ok, 0);
    end
    main_cs = 1'b0; sub_din = 16'h5a5a;
    cyc();
    chk("abset_ok", main_ok, 0);
    chk("abset_dout", main_dout, exp_dout);
    chk("abset_br", sub_br, 0);
    sub_ok = 1'b0;
    cyc();
    chk("abset_idle", busy, 0);

    for (int n = 0; n < 40; n++) begin
      if (lingering && $urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, HOLD - 2);
        repeat (w) begin cyc(); chk("linger_hold", sub_br, 1); end
        go(1, 0, 0, 0, 1'($urandom), 0, 16'h0);
      end else begin
        go(0, $urandom_range(2, 22), ($urandom_range(0, 2) == 0), $urandom_range(1, 4),
           1'($urandom), 0, 16'h0);
      end
    end
    if (lingering) linger_release();

    // asynchronous reset while settling
    chk("terr_sticky", tout_err, exp_terr);
    main_rnw = 1'b1; main_cs = 1'b1; sub_ok = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_rst_br", sub_br, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_br", sub_br, 0);
    chk("arst_ok", main_ok, 0);
    chk("arst_dout", main_dout, 16'hffff);
    chk("arst_terr", tout_err, 0);
    chk("arst_busy", busy, 0);
    main_cs = 1'b0; sub_ok = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_dout = 16'hffff; exp_terr = 1'b0;
    cyc();
    go(0, 3, 0, 0, 1, 0, 16'h0);
    if (lingering) linger_release();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
